uart_ctrl: RTL and testbench
============================

UART_CTRL -- requirements
Module: uart_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning line rate in bit/s.
REQ-003 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (legal range 5..8).
REQ-004 SHALL have parameter PARITY, default 0, meaning parity mode (0 none, 1 odd, 2 even).
REQ-005 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame (legal values 1 or 2).
REQ-006 SHALL have parameter FIFO_DEPTH, default 16, meaning RX FIFO entries (power of 2, at least 2).
REQ-007 SHALL have port clk_50m, input, 1 bit: the single clock; all logic on its rising edge.
REQ-008 SHALL have port clear, input, 1 bit: asynchronous, active-high reset.
REQ-009 SHALL have port tx_en, input, 1 bit: transmitter enable.
REQ-010 SHALL have port tx_data, input, DATA_BITS bits: word to send.
REQ-011 SHALL have port tx_valid, input, 1 bit: tx_data offered.
REQ-012 SHALL have port tx_ready, output, 1 bit: transmitter accepts a word.
REQ-013 SHALL have port tx, output, 1 bit: serial line out.
REQ-014 SHALL have port tx_busy, output, 1 bit: frame in progress.
REQ-015 SHALL have port rx, input, 1 bit: serial line in (asynchronous).
REQ-016 SHALL have port rx_en, input, 1 bit: receiver enable.
REQ-017 SHALL have port rx_data, output, DATA_BITS bits: FIFO head word.
REQ-018 SHALL have port rx_valid, output, 1 bit: FIFO not empty.
REQ-019 SHALL have port rx_ready, input, 1 bit: consumer pops the head.
REQ-020 SHALL have port rx_count, output, clog2(FIFO_DEPTH)+1 bits: FIFO occupancy.
REQ-021 SHALL have port parity_err, output, 1 bit: sticky parity-error flag.
REQ-022 SHALL have port frame_err, output, 1 bit: sticky framing-error flag.
REQ-023 SHALL have port overrun, output, 1 bit: sticky FIFO-overflow flag.
REQ-024 SHALL have port err_clr, input, 1 bit: clears all three sticky flags.

Function
REQ-025 SHALL generate a 16x oversample tick every DIV = round(CLK_HZ/(BAUD*16)) clocks; each line bit lasts 16 ticks.
REQ-026 SHALL drive tx_ready = tx_en AND TX state IDLE; a word SHALL be captured on a clock with tx_valid AND tx_ready, and tx_busy SHALL rise the following clock.
REQ-027 SHALL use TX states IDLE, START, DATA, PARITY (skipped when PARITY=0), STOP, IDLE; bit order: start bit 0, data LSB first, parity bit, STOP_BITS ones.
REQ-028 SHALL set the parity bit so the count of ones over data plus parity is odd (PARITY=1) or even (PARITY=2).
REQ-029 SHALL drop tx_busy and return to IDLE after the final stop bit; deasserting tx_en mid-frame SHALL NOT abort the frame.
REQ-030 SHALL pass rx through a 2-flop synchronizer before any use.
REQ-031 SHALL use RX states IDLE, START, DATA, PARITY, STOP; a synchronized falling edge SHALL move IDLE to START, with each bit sampled at tick 8 of its bit period.
REQ-032 SHALL return from START to IDLE with no push and no error when the start sample reads 1 (false start).
REQ-033 SHALL set parity_err on parity mismatch and frame_err when the first stop sample reads 0; the word SHALL still be pushed in both cases.
REQ-034 SHALL push the word at the first stop-bit sample; the receiver SHALL then reach IDLE and rearm without waiting for a second stop bit.
REQ-035 SHALL, on a push while the FIFO is full without a same-cycle pop, drop the new word, keep the stored contents, and set overrun.
REQ-036 SHALL, on a same-cycle push and pop, perform both, leaving rx_count unchanged, including when the FIFO is full.
REQ-037 SHALL present rx_data show-ahead (head valid whenever rx_valid=1); pointers SHALL wrap modulo FIFO_DEPTH.
REQ-038 SHALL give err_clr priority over a same-cycle error set, so the flag reads 0 the next clock.
REQ-039 SHALL, while rx_en=0, hold the receiver in IDLE and make no pushes; FIFO pops SHALL still operate.

Reset
REQ-040 SHALL, on clear, immediately force tx=1, tx_busy=0, tx_ready=0, rx_valid=0, rx_count=0 and all error flags 0, abandoning any frame in progress.
REQ-041 SHALL release on the first clock edge after clear deasserts, with both state machines in IDLE and the tick counter at 0.

Structure
REQ-042 SHALL take the parity-mode constants (PAR_NONE, PAR_ODD, PAR_EVEN) and the TX/RX state encodings from the shared package uart_pkg.
REQ-043 SHALL implement the RX FIFO as sub-module uart_fifo (parameters WIDTH, DEPTH); the baud tick, TX logic and RX logic SHALL be inline.

Verification
REQ-044 SHALL cover: defaults, tx_data=0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 432 clocks (DIV=27), tx_busy high for 4320 clocks.
REQ-045 SHALL cover: PARITY=2, send 0x07 -> parity bit 1; loop back into rx -> rx_data=0x07, parity_err=0.
REQ-046 SHALL cover: FIFO_DEPTH=4, receive 0x11..0x15 with no pops -> rx_count=4, overrun=1, pops yield 0x11..0x14.
REQ-047 SHALL cover: frame with stop bit 0, data 0x3C -> frame_err=1 and 0x3C in FIFO; err_clr pulse -> frame_err=0.
REQ-048 SHALL cover: 5-clock low glitch on rx -> no push, no error flags; clear asserted mid-TX-frame -> tx=1 immediately and the next word is accepted normally.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - parity modes, FSM encodings and parity helper shared by the UART
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

  // Zero-extended upper bits do not change the XOR, so narrow words can be passed in.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    return (mode == PAR_ODD) ? ~(^data) : ^data;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - show-ahead RX FIFO; full-FIFO pushes are dropped unless a pop frees a slot
module uart_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   CNT_MAX = DEPTH;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o    = (count_q == CNT_MAX);
  assign empty_o   = (count_q == '0);
  assign do_pop    = pop_i && !empty_o;
  assign do_push   = push_i && (!full_o || do_pop);
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) count_d = count_q + CNT_ONE;
    if (!do_push && do_pop) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_ctrl.sv
// rtl/uart_ctrl.sv - UART with 16x oversampled TX/RX, RX FIFO and sticky error flags
module uart_ctrl #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                         clk_50m,
  input  logic                         clear,
  input  logic                         tx_en,
  input  logic [DATA_BITS-1:0]         tx_data,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  output logic                         tx,
  output logic                         tx_busy,
  input  logic                         rx,
  input  logic                         rx_en,
  output logic [DATA_BITS-1:0]         rx_data,
  output logic                         rx_valid,
  input  logic                         rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]  rx_count,
  output logic                         parity_err,
  output logic                         frame_err,
  output logic                         overrun,
  input  logic                         err_clr
);
  import uart_pkg::*;

  localparam int DIV  = (CLK_HZ + BAUD * 8) / (BAUD * 16);
  localparam int DIVW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(DIV - 1);
  localparam logic [DIVW-1:0] DIV_ONE  = 1;

  logic [DIVW-1:0] div_q, div_d;
  logic            tick, tx_start, run_q;

  tx_state_e              tx_state_q, tx_state_d;
  logic [3:0]             tx_tick_q, tx_tick_d;
  logic [2:0]             tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0]   tx_shift_q, tx_shift_d;
  logic                   tx_par_q, tx_par_d, tx_q, tx_d, tx_bit_end;

  rx_state_e              rx_state_q, rx_state_d;
  logic [3:0]             rx_tick_q, rx_tick_d;
  logic [2:0]             rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_d;
  logic                   rx_s1_q, rx_s2_q, rx_prev_q, rx_fall, rx_sample;
  logic                   rx_perr_q, rx_perr_d, rx_push, perr_set, ferr_set;
  logic                   parity_err_q, parity_err_d, frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d, fifo_full, fifo_empty, rx_pop;

  // Restarting the divider on TX capture makes every TX bit exactly 16*DIV clocks;
  // an RX frame in flight only sees its sample point shift by under one tick.
  assign tick    = (div_q == DIV_LAST);
  assign div_d   = (tx_start || tick) ? '0 : div_q + DIV_ONE;

  assign tx_ready   = tx_en && run_q && (tx_state_q == TX_IDLE);
  assign tx_busy    = (tx_state_q != TX_IDLE);
  assign tx         = tx_q;
  assign tx_bit_end = tick && (tx_tick_q == 4'd15);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_tick_d  = tx_tick_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_start   = 1'b0;
    if (tx_state_q != TX_IDLE && tick) tx_tick_d = tx_tick_q + 4'd1;
    case (tx_state_q)
      TX_IDLE: if (tx_valid && tx_ready) begin
        tx_start   = 1'b1;
        tx_shift_d = tx_data;
        tx_par_d   = parity_bit(8'(tx_data), PARITY);
        tx_tick_d  = '0;
        tx_bit_d   = '0;
        tx_state_d = TX_START;
      end
      TX_START: if (tx_bit_end) tx_state_d = TX_DATA;
      TX_DATA: if (tx_bit_end) begin
        tx_shift_d = tx_shift_q >> 1;
        if (tx_bit_q == 3'(DATA_BITS - 1)) begin
          tx_bit_d   = '0;
          tx_state_d = (PARITY != PAR_NONE) ? TX_PARITY : TX_STOP;
        end else begin
          tx_bit_d = tx_bit_q + 3'd1;
        end
      end
      TX_PARITY: if (tx_bit_end) tx_state_d = TX_STOP;
      TX_STOP: if (tx_bit_end) begin
        if (tx_bit_q == 3'(STOP_BITS - 1)) tx_state_d = TX_IDLE;
        else tx_bit_d = tx_bit_q + 3'd1;
      end
      default: tx_state_d = TX_IDLE;
    endcase
    case (tx_state_d)
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = tx_shift_d[0];
      TX_PARITY: tx_d = tx_par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  assign rx_fall   = rx_prev_q && !rx_s2_q;
  assign rx_sample = tick && (rx_tick_q == 4'd7);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_tick_d  = rx_tick_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_perr_d  = rx_perr_q;
    rx_push    = 1'b0;
    perr_set   = 1'b0;
    ferr_set   = 1'b0;
    if (rx_state_q != RX_IDLE && tick) rx_tick_d = rx_tick_q + 4'd1;
    case (rx_state_q)
      RX_IDLE: if (rx_fall) begin
        rx_tick_d  = '0;
        rx_state_d = RX_START;
      end
      RX_START: if (rx_sample) begin
        if (rx_s2_q) begin
          rx_state_d = RX_IDLE;
        end else begin
          rx_bit_d   = '0;
          rx_perr_d  = 1'b0;
          rx_state_d = RX_DATA;
        end
      end
      RX_DATA: if (rx_sample) begin
        rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
        if (rx_bit_q == 3'(DATA_BITS - 1)) begin
          rx_state_d = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
        end else begin
          rx_bit_d = rx_bit_q + 3'd1;
        end
      end
      RX_PARITY: if (rx_sample) begin
        rx_perr_d  = (rx_s2_q != parity_bit(8'(rx_shift_q), PARITY));
        rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_sample) begin
        rx_push    = 1'b1;
        ferr_set   = !rx_s2_q;
        perr_set   = rx_perr_q;
        rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
    if (!rx_en) begin
      rx_state_d = RX_IDLE;
      rx_push    = 1'b0;
      perr_set   = 1'b0;
      ferr_set   = 1'b0;
    end
  end

  assign rx_pop       = rx_ready && !fifo_empty;
  assign parity_err_d = !err_clr && (parity_err_q || perr_set);
  assign frame_err_d  = !err_clr && (frame_err_q || ferr_set);
  assign overrun_d    = !err_clr && (overrun_q || (rx_push && fifo_full && !rx_pop));
  assign parity_err   = parity_err_q;
  assign frame_err    = frame_err_q;
  assign overrun      = overrun_q;
  assign rx_valid     = !fifo_empty;

  always_ff @(posedge clk_50m or posedge clear) begin
    if (clear) begin
      div_q        <= '0;
      run_q        <= 1'b0;
      tx_state_q   <= TX_IDLE;
      tx_tick_q    <= '0;
      tx_bit_q     <= '0;
      tx_shift_q   <= '0;
      tx_par_q     <= 1'b0;
      tx_q         <= 1'b1;
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_tick_q    <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_perr_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      div_q        <= div_d;
      run_q        <= 1'b1;
      tx_state_q   <= tx_state_d;
      tx_tick_q    <= tx_tick_d;
      tx_bit_q     <= tx_bit_d;
      tx_shift_q   <= tx_shift_d;
      tx_par_q     <= tx_par_d;
      tx_q         <= tx_d;
      rx_s1_q      <= rx;
      rx_s2_q      <= rx_s1_q;
      rx_prev_q    <= rx_s2_q;
      rx_state_q   <= rx_state_d;
      rx_tick_q    <= rx_tick_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_perr_q    <= rx_perr_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_50m),
    .rst_i     (clear),
    .push_i    (rx_push),
    .data_i    (rx_shift_q),
    .pop_i     (rx_pop),
    .rd_data_o (rx_data),
    .count_o   (rx_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

endmodule

// File: tb/tb_uart_ctrl.sv
// tb/tb_uart_ctrl.sv - directed bench: instance A at defaults, instance B with even parity and a 4-deep FIFO
module tb_uart_ctrl;

  localparam int BIT_CLKS = 432;

  logic clk_50m = 1'b0;
  logic clear   = 1'b0;
  always #10 clk_50m = ~clk_50m;

  logic       tx_en_a = 1'b1, tx_valid_a = 1'b0, rx_a = 1'b1, rx_en_a = 1'b1;
  logic       rx_ready_a = 1'b0, err_clr_a = 1'b0;
  logic [7:0] tx_data_a = 8'h00;
  logic       tx_ready_a, tx_a, tx_busy_a, rx_valid_a, parity_err_a, frame_err_a, overrun_a;
  logic [7:0] rx_data_a;
  logic [4:0] rx_count_a;

  logic       tx_en_b = 1'b1, tx_valid_b = 1'b0, rx_drv_b = 1'b1, loop_b = 1'b0, rx_en_b = 1'b1;
  logic       rx_ready_b = 1'b0, err_clr_b = 1'b0;
  logic [7:0] tx_data_b = 8'h00;
  logic       rx_b, tx_ready_b, tx_b, tx_busy_b, rx_valid_b, parity_err_b, frame_err_b, overrun_b;
  logic [7:0] rx_data_b;
  logic [2:0] rx_count_b;

  assign rx_b = loop_b ? tx_b : rx_drv_b;

  int n_checks = 0;
  int n_fails  = 0;

  uart_ctrl u_dut_a (
    .clk_50m(clk_50m), .clear(clear), .tx_en(tx_en_a), .tx_data(tx_data_a),
    .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .tx(tx_a), .tx_busy(tx_busy_a),
    .rx(rx_a), .rx_en(rx_en_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
    .rx_ready(rx_ready_a), .rx_count(rx_count_a), .parity_err(parity_err_a),
    .frame_err(frame_err_a), .overrun(overrun_a), .err_clr(err_clr_a)
  );

  uart_ctrl #(.PARITY(2), .FIFO_DEPTH(4)) u_dut_b (
    .clk_50m(clk_50m), .clear(clear), .tx_en(tx_en_b), .tx_data(tx_data_b),
    .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .tx(tx_b), .tx_busy(tx_busy_b),
    .rx(rx_b), .rx_en(rx_en_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
    .rx_ready(rx_ready_b), .rx_count(rx_count_b), .parity_err(parity_err_b),
    .frame_err(frame_err_b), .overrun(overrun_b), .err_clr(err_clr_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_50m);
      #1;
    end
  endtask

  task automatic set_line(input bit to_b, input logic v);
    if (to_b) rx_drv_b = v;
    else rx_a = v;
  endtask

  // Even parity: the parity bit equals the XOR of the data so the total count of ones is even.
  task automatic ser_send(input bit to_b, input logic [7:0] d, input bit use_par, input logic stop_v);
    logic [10:0] bits;
    int n;
    bits[0]   = 1'b0;
    bits[8:1] = d;
    if (use_par) begin
      bits[9]  = ^d;
      bits[10] = stop_v;
      n = 11;
    end else begin
      bits[9]  = stop_v;
      bits[10] = 1'b1;
      n = 10;
    end
    for (int k = 0; k < n; k++) begin
      set_line(to_b, bits[k]);
      step(BIT_CLKS);
    end
    set_line(to_b, 1'b1);
    step(40);
  endtask

  task automatic tx_frame_a(input logic [7:0] d, input string tag);
    logic [9:0] bits;
    bits = {1'b1, d, 1'b0};
    chk({tag, "_ready_before"}, tx_ready_a, 1);
    tx_data_a  = d;
    tx_valid_a = 1'b1;
    step(1);
    tx_valid_a = 1'b0;
    chk({tag, "_busy_rise"}, tx_busy_a, 1);
    chk({tag, "_ready_busy"}, tx_ready_a, 0);
    for (int cyc = 0; cyc <= 10 * BIT_CLKS; cyc++) begin
      if (cyc == 1000) tx_en_a = 1'b0;
      if (cyc == 1500) tx_en_a = 1'b1;
      if (cyc % BIT_CLKS == 216 && cyc < 10 * BIT_CLKS)
        chk($sformatf("%s_bit%0d", tag, cyc / BIT_CLKS), tx_a, bits[cyc / BIT_CLKS]);
      if (cyc == BIT_CLKS - 1) chk({tag, "_start_last"}, tx_a, 0);
      if (cyc == BIT_CLKS) chk({tag, "_d0_first"}, tx_a, bits[1]);
      if (cyc == 10 * BIT_CLKS - 1) chk({tag, "_busy_last"}, tx_busy_a, 1);
      if (cyc == 10 * BIT_CLKS) begin
        chk({tag, "_busy_fall"}, tx_busy_a, 0);
        chk({tag, "_idle_line"}, tx_a, 1);
        chk({tag, "_ready_after"}, tx_ready_a, 1);
      end
      step(1);
    end
  endtask

  initial begin
    int wait_n;
    logic [7:0] exp_b;

    #2 clear = 1'b1;
    #1;
    chk("rst_tx", tx_a, 1);
    chk("rst_busy", tx_busy_a, 0);
    chk("rst_ready", tx_ready_a, 0);
    chk("rst_rx_valid", rx_valid_a, 0);
    chk("rst_rx_count", rx_count_a, 0);
    chk("rst_errs", {parity_err_a, frame_err_a, overrun_a}, 0);
    chk("rst_tx_b", tx_b, 1);
    step(3);
    clear = 1'b0;
    step(1);
    chk("release_ready", tx_ready_a, 1);

    tx_frame_a(8'hA5, "a5");

    loop_b     = 1'b1;
    tx_data_b  = 8'h07;
    tx_valid_b = 1'b1;
    step(1);
    tx_valid_b = 1'b0;
    step(4 * BIT_CLKS + 216);
    chk("lb_d3", tx_b, 0);
    step(5 * BIT_CLKS);
    chk("lb_parity_bit", tx_b, 1);
    step(BIT_CLKS);
    chk("lb_stop", tx_b, 1);
    chk("lb_busy_stop", tx_busy_b, 1);
    step(BIT_CLKS);
    chk("lb_busy_end", tx_busy_b, 0);
    wait_n = 0;
    while (rx_valid_b !== 1'b1 && wait_n < 6000) begin
      step(1);
      wait_n++;
    end
    chk("lb_valid", rx_valid_b, 1);
    chk("lb_data", rx_data_b, 8'h07);
    chk("lb_parity_err", parity_err_b, 0);
    chk("lb_count", rx_count_b, 1);
    rx_ready_b = 1'b1;
    step(1);
    rx_ready_b = 1'b0;
    chk("lb_popped", rx_count_b, 0);
    loop_b = 1'b0;

    for (int i = 0; i < 5; i++) begin
      exp_b = 8'h11 + 8'(i);
      ser_send(1'b1, exp_b, 1'b1, 1'b1);
    end
    chk("ovr_count", rx_count_b, 4);
    chk("ovr_flag", overrun_b, 1);
    chk("ovr_perr", parity_err_b, 0);
    chk("ovr_ferr", frame_err_b, 0);
    for (int i = 0; i < 4; i++) begin
      exp_b = 8'h11 + 8'(i);
      chk($sformatf("ovr_pop%0d", i), rx_data_b, exp_b);
      rx_ready_b = 1'b1;
      step(1);
      rx_ready_b = 1'b0;
    end
    chk("ovr_empty", rx_valid_b, 0);
    err_clr_b = 1'b1;
    step(1);
    err_clr_b = 1'b0;
    chk("ovr_clr", overrun_b, 0);

    ser_send(1'b0, 8'h3C, 1'b0, 1'b0);
    chk("fe_flag", frame_err_a, 1);
    chk("fe_perr", parity_err_a, 0);
    chk("fe_count", rx_count_a, 1);
    chk("fe_data", rx_data_a, 8'h3C);
    err_clr_a = 1'b1;
    step(1);
    err_clr_a = 1'b0;
    chk("fe_clr", frame_err_a, 0);
    chk("fe_word_kept", rx_valid_a, 1);
    rx_ready_a = 1'b1;
    step(1);
    rx_ready_a = 1'b0;
    chk("fe_popped", rx_count_a, 0);

    rx_a = 1'b0;
    step(5);
    rx_a = 1'b1;
    step(600);
    chk("glitch_count", rx_count_a, 0);
    chk("glitch_errs", {parity_err_a, frame_err_a, overrun_a}, 0);

    rx_en_a = 1'b0;
    ser_send(1'b0, 8'h55, 1'b0, 1'b1);
    chk("rx_dis_count", rx_count_a, 0);
    rx_en_a = 1'b1;

    tx_data_a  = 8'h5A;
    tx_valid_a = 1'b1;
    step(1);
    tx_valid_a = 1'b0;
    step(100);
    chk("mid_start_bit", tx_a, 0);
    clear = 1'b1;
    #2;
    chk("clr_tx", tx_a, 1);
    chk("clr_busy", tx_busy_a, 0);
    chk("clr_ready", tx_ready_a, 0);
    @(posedge clk_50m);
    #1;
    clear = 1'b0;
    step(1);
    tx_frame_a(8'h81, "post_clr");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
